// File: rtl/alu_mc_pkg.sv
// alu_pkg: function codes, flag bit positions and saturation constants for alu_mc.
// Shared by the ALU, its bus interface and anything that issues operations.
// Pure declarations; no logic.
package alu_pkg;

  // Function codes; codes 9..15 behave like FA (pass a through).
  typedef enum logic [3:0] {
    FA   = 4'd0,
    FB   = 4'd1,
    FADD = 4'd2,
    FSUB = 4'd3,
    FMUL = 4'd4,
    FAND = 4'd5,
    FOR  = 4'd6,
    FXOR = 4'd7,
    FNOR = 4'd8
  } func_t;

  // Bit positions inside the 4-bit {V,N,Z,C} flag word.
  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Largest positive n-bit two's complement value (0111..1), zero-extended to 64 bits.
  function automatic logic [63:0] sat_pos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Most negative n-bit two's complement value (1000..0), zero-extended to 64 bits.
  function automatic logic [63:0] sat_neg(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between an operation issuer and alu_mc.
// Request side is valid/ready; response side is a one-cycle out_valid pulse.
// No response backpressure: the issuer must capture result on out_valid.
interface alu_mc_if #(parameter int N = 8);
  import alu_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [3:0]   func;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         clear_sticky;
  logic         out_valid;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         sticky_v;

  modport master (
    output in_valid, func, a, b, clear_sticky,
    input  in_ready, out_valid, result, flags, sticky_v
  );

  modport slave (
    input  in_valid, func, a, b, clear_sticky,
    output in_ready, out_valid, result, flags, sticky_v
  );

endinterface

// File: rtl/alu_mc_seq_mul.sv
// seq_mul: iterative signed N x N multiplier, shift-add on magnitudes with final sign fix-up.
// Latency: start accepted at edge 0, done high during cycle N with the full 2N-bit product.
// No backpressure: start is ignored while busy; product is only meaningful while done=1.
module seq_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]   mcand;
  logic [N-1:0]   hi;
  logic [N-1:0]   lo;
  logic           neg;
  logic [CW-1:0]  cnt;
  logic           busy_q;
  logic [N:0]     step_sum;
  logic [N-1:0]   nxt_hi;
  logic [N-1:0]   nxt_lo;
  logic [2*N-1:0] mag;

  // Magnitude of a two's complement value; the most negative value maps to 2^(N-1), which still fits unsigned.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] x);
    return x[N-1] ? (~x + 1'b1) : x;
  endfunction

  // One partial-product step: conditionally add the multiplicand to the high half, then shift right.
  // The product output is the post-step value so the owner can capture it on the same edge as the last step.
  always_comb begin
    step_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    nxt_hi   = step_sum[N:1];
    nxt_lo   = {step_sum[0], lo[N-1:1]};
    mag      = {nxt_hi, nxt_lo};
    product  = neg ? (~mag + 1'b1) : mag;
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt == CW'(1));

  // Load magnitudes on start, then run exactly N steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      mcand  <= magnitude(a);
      hi     <= '0;
      lo     <= magnitude(b);
      neg    <= a[N-1] ^ b[N-1];
      cnt    <= CW'(N);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (move/add/sub/logic in one cycle, fractional signed multiply over N cycles).
// Latency: single-cycle ops complete one cycle after accept; MUL completes N+1 cycles after accept.
// Backpressure: in_ready drops for the N multiply cycles; no output backpressure (result held until next completion).
module alu_mc
  import alu_pkg::*;
#(
  parameter int N    = 8,
  parameter int FRAC = N - 1,
  parameter int SAT  = 0
) (
  input  logic clk,
  input  logic reset,
  alu_mc_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [63:0]  SAT_POS_W = sat_pos(N);
  localparam logic [63:0]  SAT_NEG_W = sat_neg(N);
  localparam logic [N-1:0] SAT_POS   = SAT_POS_W[N-1:0];
  localparam logic [N-1:0] SAT_NEG   = SAT_NEG_W[N-1:0];

  logic [0:0]     state;
  logic [CW-1:0]  cnt;
  logic           out_valid_q;
  logic [N-1:0]   result_q;
  logic [3:0]     flags_q;
  logic           sticky_q;

  logic           accept;
  logic           mul_start;
  logic           mul_busy;
  logic           mul_done;
  logic           mul_fin;
  logic           complete;
  logic [2*N-1:0] product;
  logic signed [2*N-1:0] prod_top;
  logic           mul_ovf;

  func_t          op;
  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [N-1:0]   raw;
  logic [N-1:0]   res;
  logic [3:0]     flg;
  logic           v;
  logic           c;
  logic           neg;

  assign bus.in_ready  = (state == S_IDLE) && !mul_busy;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.sticky_v  = sticky_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign mul_start = accept && (bus.func == FMUL);
  assign mul_fin   = (state == S_MUL) && (cnt == CW'(1)) && mul_done;
  assign complete  = (accept && (bus.func != FMUL)) || mul_fin;

  seq_mul #(.N(N)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  // Product overflows the selected window when everything from bit FRAC+N-1 upward is not a pure sign extension.
  assign prod_top = $signed(product) >>> (FRAC + N - 1);
  assign mul_ovf  = !((prod_top == '0) || (prod_top == '1));

  // Datapath: raw result, V/C and true sign per op, then optional saturation and N/Z from the final value.
  always_comb begin
    op   = (state == S_MUL) ? FMUL : func_t'(bus.func);
    sum  = {1'b0, bus.a} + {1'b0, bus.b};
    diff = {1'b0, bus.a} - {1'b0, bus.b};
    raw  = bus.a;
    v    = 1'b0;
    c    = 1'b0;
    neg  = 1'b0;
    case (op)
      FB:   raw = bus.b;
      FADD: begin
        raw = sum[N-1:0];
        c   = sum[N];
        v   = (bus.a[N-1] == bus.b[N-1]) && (raw[N-1] != bus.a[N-1]);
        neg = bus.a[N-1];
      end
      FSUB: begin
        raw = diff[N-1:0];
        c   = diff[N];
        v   = (bus.a[N-1] != bus.b[N-1]) && (raw[N-1] != bus.a[N-1]);
        neg = bus.a[N-1];
      end
      FMUL: begin
        raw = product[FRAC +: N];
        v   = mul_ovf;
        neg = product[2*N-1];
      end
      FAND: raw = bus.a & bus.b;
      FOR:  raw = bus.a | bus.b;
      FXOR: raw = bus.a ^ bus.b;
      FNOR: raw = ~(bus.a | bus.b);
      default: raw = bus.a;
    endcase
    res = ((SAT != 0) && v) ? (neg ? SAT_NEG : SAT_POS) : raw;
    flg         = '0;
    flg[FLAG_V] = v;
    flg[FLAG_N] = res[N-1];
    flg[FLAG_Z] = (res == '0);
    flg[FLAG_C] = c;
  end

  // Handshake FSM plus result/flags/sticky registers; a V completion beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mul_start) begin
            state <= S_MUL;
            cnt   <= CW'(N);
          end
        end
        default: begin
          cnt <= cnt - CW'(1);
          if (mul_fin) begin
            state <= S_IDLE;
          end
        end
      endcase
      if (complete) begin
        result_q    <= res;
        flags_q     <= flg;
        out_valid_q <= 1'b1;
      end
      if (complete && flg[FLAG_V]) begin
        sticky_q <= 1'b1;
      end else if (bus.clear_sticky) begin
        sticky_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed plus random operations on two alu_mc instances (wrap and saturate) in lockstep.
// Expected result/flags come from an integer-arithmetic reference model of the ALU rules.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int N    = 8;
  localparam int FRAC = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mc_if #(.N(N)) bw ();
  alu_mc_if #(.N(N)) bs ();

  alu_mc #(.N(N), .FRAC(FRAC), .SAT(0)) u_wrap (.clk(clk), .reset(reset), .bus(bw.slave));
  alu_mc #(.N(N), .FRAC(FRAC), .SAT(1)) u_sat  (.clk(clk), .reset(reset), .bus(bs.slave));

  int   vectors     = 0;
  int   miscompares = 0;
  logic model_sticky = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] f, input logic [7:0] x,
                       input logic [7:0] y, input logic clr);
    bw.in_valid = vld; bw.func = f; bw.a = x; bw.b = y; bw.clear_sticky = clr;
    bs.in_valid = vld; bs.func = f; bs.a = x; bs.b = y; bs.clear_sticky = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: returns {V,N,Z,C, result[7:0]} from signed/unsigned integer arithmetic.
  function automatic logic [11:0] model(input logic [3:0] f, input logic [7:0] x,
                                        input logic [7:0] y, input bit sat);
    int sa, sb, ua, ub, t;
    bit v, c, arith;
    logic [7:0] r;
    sa = $signed(x); sb = $signed(y); ua = x; ub = y;
    t = 0; v = 0; c = 0; arith = 0; r = x;
    case (f)
      FB:   r = y;
      FADD: begin t = sa + sb; c = (ua + ub) > 255; arith = 1; end
      FSUB: begin t = sa - sb; c = (ua < ub);       arith = 1; end
      FMUL: begin t = (sa * sb) >>> FRAC;           arith = 1; end
      FAND: r = x & y;
      FOR:  r = x | y;
      FXOR: r = x ^ y;
      FNOR: r = ~(x | y);
      default: r = x;
    endcase
    if (arith) begin
      v = (t > 127) || (t < -128);
      r = t[7:0];
      if (sat && v) r = (t < 0) ? 8'h80 : 8'h7F;
    end
    return {v, r[7], (r == 8'h00), c, r};
  endfunction

  task automatic check_out(input string tag, input logic [11:0] ew, input logic [11:0] es);
    check({tag, "_ovld_w"}, bw.out_valid, 1);
    check({tag, "_ovld_s"}, bs.out_valid, 1);
    check({tag, "_res_w"}, bw.result, ew[7:0]);
    check({tag, "_flg_w"}, bw.flags, ew[11:8]);
    check({tag, "_res_s"}, bs.result, es[7:0]);
    check({tag, "_flg_s"}, bs.flags, es[11:8]);
    check({tag, "_stk_w"}, bw.sticky_v, model_sticky);
    check({tag, "_stk_s"}, bs.sticky_v, model_sticky);
  endtask

  // Issue one op from an idle-ready point and follow it to completion; inputs are scrambled after accept.
  task automatic do_op(input string tag, input logic [3:0] f, input logic [7:0] x,
                       input logic [7:0] y, input logic clr);
    logic [11:0] ew, es;
    ew = model(f, x, y, 0);
    es = model(f, x, y, 1);
    check({tag, "_rdy"}, bw.in_ready & bs.in_ready, 1);
    drive(1, f, x, y, clr);
    tick();
    drive(0, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 0);
    if (f == FMUL) begin
      for (int k = 1; k <= N; k++) begin
        check({tag, "_busy_rdy"}, bw.in_ready | bs.in_ready, 0);
        check({tag, "_busy_ovld"}, bw.out_valid | bs.out_valid, 0);
        tick();
      end
    end
    model_sticky = (clr ? 1'b0 : model_sticky) | ew[11];
    check_out(tag, ew, es);
  endtask

  initial begin
    logic [11:0] ew, es;
    logic [3:0]  rf;
    logic [7:0]  rx, ry;
    logic        rc;

    reset = 1'b1;
    drive(0, FA, 8'h00, 8'h00, 0);
    repeat (3) tick();
    reset = 1'b0;
    check("rst_rdy", bw.in_ready, 1);
    check("rst_ovld", bw.out_valid, 0);
    check("rst_res", bw.result, 0);
    check("rst_flg", bw.flags, 0);
    check("rst_stk", bw.sticky_v, 0);

    do_op("add_ovf", FADD, 8'h7F, 8'h01, 0);
    tick();
    check("idle_ovld", bw.out_valid, 0);

    drive(0, FA, 8'h00, 8'h00, 1);
    tick();
    drive(0, FA, 8'h00, 8'h00, 0);
    model_sticky = 1'b0;
    check("clr_stk_w", bw.sticky_v, 0);
    check("clr_stk_s", bs.sticky_v, 0);

    do_op("add_ovf_clr", FADD, 8'h7F, 8'h01, 1);
    tick();

    // Back-to-back SUBs: second is offered while the first completes.
    drive(1, FSUB, 8'h05, 8'h05, 0);
    tick();
    drive(1, FSUB, 8'h00, 8'h01, 0);
    ew = model(FSUB, 8'h05, 8'h05, 0);
    es = model(FSUB, 8'h05, 8'h05, 1);
    check("b2b_rdy", bw.in_ready, 1);
    check_out("sub_zero", ew, es);
    tick();
    drive(0, FA, 8'h00, 8'h00, 0);
    ew = model(FSUB, 8'h00, 8'h01, 0);
    es = model(FSUB, 8'h00, 8'h01, 1);
    check_out("sub_borrow", ew, es);
    tick();

    do_op("mul_half", FMUL, 8'h40, 8'h40, 0);
    do_op("add_after_mul", FADD, 8'h10, 8'h20, 0);
    do_op("mul_m1sq", FMUL, 8'h80, 8'h80, 0);
    do_op("mul_neg", FMUL, 8'hC0, 8'h40, 0);
    tick();

    // Reset in cycle 4 of a MUL aborts it.
    drive(1, FMUL, 8'h40, 8'h40, 0);
    tick();
    drive(0, FA, 8'h00, 8'h00, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_sticky = 1'b0;
    check("abort_rdy", bw.in_ready & bs.in_ready, 1);
    check("abort_res", bw.result, 0);
    check("abort_flg", bw.flags, 0);
    check("abort_stk", bw.sticky_v, 0);
    for (int k = 0; k < 12; k++) begin
      check("abort_ovld", bw.out_valid | bs.out_valid, 0);
      tick();
    end
    do_op("add_post_rst", FADD, 8'h01, 8'h02, 0);

    // Random ops, with occasional clears and idle gaps.
    for (int i = 0; i < 80; i++) begin
      rf = 4'($urandom_range(0, 15));
      rx = 8'($urandom);
      ry = 8'($urandom);
      rc = ($urandom_range(0, 5) == 0);
      do_op("rnd", rf, rx, ry, rc);
      if ($urandom_range(0, 2) == 0) begin
        tick();
        check("rnd_gap_ovld", bw.out_valid | bs.out_valid, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
